// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_datapath.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// acc holds the product high half / partial remainder; qm holds the multiplier / quotient.
module mdu_iter_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] qm,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] qm_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, acc} + (qm[0] ? {1'b0, opnd} : '0);
    shifted = {acc, qm[WIDTH-1]};
    trial   = shifted - {1'b0, opnd};
    if (is_div) begin
      // A clear top bit means the trial subtraction did not borrow.
      if (!trial[WIDTH]) begin
        acc_next = trial[WIDTH-1:0];
        qm_next  = {qm[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        qm_next  = {qm[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = sum[WIDTH:1];
      qm_next  = {sum[0], qm[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; one iteration per cycle,
// operating on magnitudes with a sign fix-up cycle at the end.
module mult_div_unit #(
  parameter int unsigned WIDTH = mdu_pkg::WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mdu_pkg::*;

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_e;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, qm_q, qm_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d, sign_x_q, sign_x_d;
  logic             done_q, done_d;

  logic             is_signed, a_neg, b_neg, op_is_div;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] acc_step, qm_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem;

  mdu_iter_datapath #(
    .WIDTH (WIDTH)
  ) u_iter (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .qm       (qm_q),
    .opnd     (opnd_q),
    .acc_next (acc_step),
    .qm_next  (qm_step)
  );

  always_comb begin
    op_e      = mdu_op_e'(op);
    is_signed = (op_e == MDU_MULT) || (op_e == MDU_DIV);
    op_is_div = (op_e == MDU_DIV) || (op_e == MDU_DIVU);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    abs_a     = a_neg ? -a : a;
    abs_b     = b_neg ? -b : b;
    prod      = sign_x_q ? -{acc_q, qm_q} : {acc_q, qm_q};
    quot      = sign_x_q ? -qm_q : qm_q;
    // Negating |a| restores the raw dividend, which also covers divide by zero.
    rem       = sign_a_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qm_d     = qm_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_x_d = sign_x_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          case (op_e)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              is_div_d = op_is_div;
              sign_a_d = a_neg;
              sign_x_d = a_neg ^ b_neg;
              acc_d    = '0;
              cnt_d    = '0;
              qm_d     = op_is_div ? abs_a : abs_b;
              opnd_d   = op_is_div ? abs_b : abs_a;
              state_d  = StRun;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_step;
          qm_d  = qm_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem;
            lo_d = (opnd_q == '0) ? '1 : quot;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      qm_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_x_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qm_q     <= qm_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_x_q <= sign_x_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
